// File: rtl/fb_load_arbiter.sv
// fb_load_arbiter
//   Parses UART image frames (sync byte, then NUM_PIX little-endian 2-byte pixels) and
//   queues each 9-bit pixel into a small write FIFO. The FIFO drains into the single-port
//   frame-buffer RAM only on cycles the VGA fetch does not need it; video reads always win.
// Ports
//   clk_in, reset          clock, synchronous active-high reset
//   rx_data, rx_valid      UART byte and its 1-cycle strobe
//   vid_req, vid_addr      VGA read request and address
//   vid_data, vid_data_valid  read data (ram_rdata) and its 1-cycle-delayed qualifier
//   ram_addr, ram_we, ram_wdata, ram_rdata  frame-buffer RAM port
//   loading                frame reception in progress
//   frame_done, frame_abort  1-cycle completion / timeout pulses
//   overflow               sticky: a pixel was dropped on a full FIFO (cleared by next sync)
module fb_load_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned NUM_PIX    = 12288,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter int unsigned TIMEOUT    = 12000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [8:0]        vid_data,
  output logic              vid_data_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [8:0]        ram_wdata,
  input  logic [8:0]        ram_rdata,
  output logic              loading,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overflow
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned EntW  = ADDR_W + 9;

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e            state_q, state_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              vid_valid_q;

  logic [EntW-1:0]   fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, push_ok, pop, full, empty;
  logic [EntW-1:0]   head;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rd_ptr_q];
  assign push_ok = push && !full;

  // Parser FSM and timeout
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    pix_cnt_d  = pix_cnt_q;
    idle_d     = idle_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        idle_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = StLo;
          pix_cnt_d  = '0;
          overflow_d = 1'b0;
        end
      end
      StLo: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          state_d = StHi;
        end
      end
      StHi: begin
        if (rx_valid) begin
          push = 1'b1;
          if (full) overflow_d = 1'b1;
          if (pix_cnt_q == ADDR_W'(NUM_PIX - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = StLo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle) begin
      if (rx_valid) begin
        idle_d = '0;
      end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
        state_d = StIdle;
        abort_d = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= StIdle;
      lo_q        <= '0;
      pix_cnt_q   <= '0;
      idle_q      <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      pix_cnt_q   <= pix_cnt_d;
      idle_q      <= idle_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      vid_valid_q <= vid_req;
    end
  end

  // Arbiter: video read has strict priority; otherwise drain one FIFO entry per cycle.
  always_comb begin
    pop       = !vid_req && !empty;
    ram_we    = pop && !reset;
    ram_addr  = pop ? head[EntW-1:9] : vid_addr;
    ram_wdata = head[8:0];
  end

  // FIFO pointers/count
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_q[wr_ptr_q] <= {pix_cnt_q, rx_data[0], lo_q};
  end

  assign vid_data       = ram_rdata;
  assign vid_data_valid = vid_valid_q;
  assign loading        = (state_q != StIdle);
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_fb_load_arbiter.sv
module tb_fb_load_arbiter;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned NUM_PIX = 2;
  localparam int unsigned TIMEOUT = 16;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [8:0]        vid_data;
  logic              vid_data_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [8:0]        ram_wdata;
  logic [8:0]        ram_rdata = '0;
  logic              loading, frame_done, frame_abort, overflow;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int we_while_vid = 0;

  logic [ADDR_W+8:0] wq[$];
  logic [8:0]        vq[$];
  logic [8:0]        mem [2**ADDR_W];

  fb_load_arbiter #(
    .ADDR_W(ADDR_W), .NUM_PIX(NUM_PIX), .SYNC_BYTE(8'hAA), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_data_valid(vid_data_valid), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .loading(loading),
    .frame_done(frame_done), .frame_abort(frame_abort), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: registered read, write-enable port
  always @(posedge clk_in) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Monitor: pops scoreboard entries whenever the DUT presents a write or a read result.
  always @(negedge clk_in) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
    if (ram_we === 1'b1 && vid_req) we_while_vid++;
    if (ram_we === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", ram_addr, ram_wdata);
      end else begin
        logic [ADDR_W+8:0] e;
        e = wq.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h want addr=%0h data=%0h",
                   ram_addr, ram_wdata, e[ADDR_W+8:9], e[8:0]);
        end
      end
    end
    if (vid_data_valid === 1'b1 && vq.size() != 0) begin
      logic [8:0] v;
      v = vq.pop_front();
      checks++;
      if (vid_data !== v) begin
        errors++;
        $display("FAIL vid_data got=%0h want=%0h", vid_data, v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [8:0] d);
    wq.push_back({a, d});
  endtask

  initial begin
    int d0, a0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    mem[5] = 9'h1FF;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk_in);
    chk("rst_loading", {31'd0, loading}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_vid_valid", {31'd0, vid_data_valid}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    tick();

    // 1: basic two-pixel frame
    d0 = done_cnt;
    exp_wr(14'd0, 9'h134);
    exp_wr(14'd1, 9'h012);
    send(8'hAA); send(8'h34); send(8'h01); send(8'h12); send(8'h00);
    repeat (3) tick();
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_loading", {31'd0, loading}, 32'd0);

    // 2: non-sync bytes ignored in idle
    send(8'h55); send(8'h77);
    chk("t2_ignored", {31'd0, loading}, 32'd0);
    send(8'hAA);
    chk("t2_sync", {31'd0, loading}, 32'd1);

    // 5: timeout mid-frame
    a0 = abort_cnt;
    send(8'h10);
    repeat (TIMEOUT - 4) tick();
    chk("t5_still_loading", {31'd0, loading}, 32'd1);
    repeat (6) tick();
    chk("t5_abort_once", abort_cnt - a0, 32'd1);
    chk("t5_idle", {31'd0, loading}, 32'd0);

    // 3: video starves writes, 5th pixel dropped
    vid_req  = 1'b1;
    vid_addr = 14'd3;
    exp_wr(14'd0, 9'h001); exp_wr(14'd1, 9'h002);
    exp_wr(14'd0, 9'h003); exp_wr(14'd1, 9'h004);
    send(8'hAA); send(8'h01); send(8'h00); send(8'h02); send(8'h00);
    send(8'hAA); send(8'h03); send(8'h00); send(8'h04); send(8'h00);
    send(8'hAA); send(8'h05); send(8'h00);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    vid_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk($sformatf("t3_drain%0d", i), {31'd0, ram_we}, 32'd1);
    end
    @(negedge clk_in);
    chk("t3_drained", {31'd0, ram_we}, 32'd0);
    repeat (TIMEOUT + 5) tick();

    // 4: video read returns RAM contents one cycle later
    vid_addr = 14'd5;
    vid_req  = 1'b1;
    vq.push_back(9'h1FF);
    tick();
    vid_req = 1'b0;
    repeat (3) tick();

    // 6: reset mid-frame with 2 entries pending
    vid_req = 1'b1;
    send(8'hAA); send(8'h21); send(8'h00); send(8'h22); send(8'h00);
    send(8'hAA); send(8'h23);
    chk("t6_loading", {31'd0, loading}, 32'd1);
    reset   = 1'b1;
    vid_req = 1'b0;
    @(negedge clk_in);
    chk("t6_we_in_reset", {31'd0, ram_we}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk_in);
    chk("t6_we_after", {31'd0, ram_we}, 32'd0);
    chk("t6_loading_after", {31'd0, loading}, 32'd0);
    chk("t6_overflow_after", {31'd0, overflow}, 32'd0);
    tick();
    exp_wr(14'd0, 9'h131);
    exp_wr(14'd1, 9'h032);
    send(8'hAA); send(8'h31); send(8'h01); send(8'h32); send(8'h00);
    repeat (5) tick();

    chk("writes_outstanding", wq.size(), 32'd0);
    chk("reads_outstanding", vq.size(), 32'd0);
    chk("we_during_vid", we_while_vid, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
